// File: rtl/dmem_bridge.sv
// dmem_bridge: load/store unit to data-memory bus bridge.
// One access per instruction: latch the request, run a valid/ready
// transaction with a timeout, stall the core until it completes, and
// return load data right-aligned to byte 0.
module dmem_bridge #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_rd,
   input  logic [3:0]  dmem_wr,
   input  logic [31:0] data_addr,
   input  logic [31:0] datamem_wr_o,
   output logic [31:0] rd_data,
   output logic        stall,
   output logic        bus_err,
   output logic        bus_valid,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

   // Last counter value before the access is aborted.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  off_q, off_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic        req;

   assign req = req_rd | (|dmem_wr);

   // Next-state, latched request fields, timeout counter and stall.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      off_d     = off_q;
      we_d      = we_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      rd_data_d = rd_data_q;
      stall     = 1'b0;
      case (state_q)
         S_IDLE: begin
            stall = req;
            if (req) begin
               // A store wins over a simultaneous load request.
               we_d    = |dmem_wr;
               be_d    = (|dmem_wr) ? dmem_wr : 4'b1111;
               addr_d  = {data_addr[31:2], 2'b00};
               off_d   = data_addr[1:0];
               wdata_d = datamem_wr_o;
               cnt_d   = 8'd0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            stall = 1'b1;
            // Ready is checked first so a late handshake still completes.
            if (bus_ready) begin
               if (!we_q) rd_data_d = bus_rdata >> {off_q, 3'b000};
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               if (!we_q) rd_data_d = 32'd0;
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         // Requests seen here belong to the instruction being committed.
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      valid_d = (state_d == S_REQ);
      err_d   = (state_d == S_ERR);
   end

   // All state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         off_q     <= 2'd0;
         we_q      <= 1'b0;
         addr_q    <= 32'd0;
         be_q      <= 4'd0;
         wdata_q   <= 32'd0;
         rd_data_q <= 32'd0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         off_q     <= off_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         rd_data_q <= rd_data_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign rd_data   = rd_data_q;
   assign bus_err   = err_q;
   assign bus_valid = valid_q;
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_be    = be_q;
   assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge with TIMEOUT = 4.
module tb_dmem_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_rd;
   logic [3:0]  dmem_wr;
   logic [31:0] data_addr;
   logic [31:0] datamem_wr_o;
   logic [31:0] rd_data;
   logic        stall;
   logic        bus_err;
   logic        bus_valid;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   int tests = 0;
   int fails = 0;

   dmem_bridge #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .req_rd(req_rd), .dmem_wr(dmem_wr),
      .data_addr(data_addr), .datamem_wr_o(datamem_wr_o), .rd_data(rd_data),
      .stall(stall), .bus_err(bus_err), .bus_valid(bus_valid), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ready(bus_ready), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   // Advance one cycle; registered outputs are settled 2 time units after the edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      req_rd = 1'b0; dmem_wr = 4'd0; data_addr = 32'd0; datamem_wr_o = 32'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle_inputs(); bus_ready = 1'b0; bus_rdata = 32'd0;
      tick(); tick();
      tests++;
      if ({bus_valid, bus_err, bus_we, stall} !== 4'b0000) begin
         fails++; $display("FAIL reset_ctrl got %b want 0000", {bus_valid, bus_err, bus_we, stall});
      end
      tests++;
      if ({rd_data, bus_addr, bus_wdata, bus_be} !== 100'd0) begin
         fails++; $display("FAIL reset_data got rd=%h addr=%h wd=%h be=%b want zeros", rd_data, bus_addr, bus_wdata, bus_be);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_word_store();
      data_addr = 32'h100; dmem_wr = 4'b1111; datamem_wr_o = 32'hDEADBEEF; bus_ready = 1'b1;
      #1;
      tests++;
      if (stall !== 1'b1) begin fails++; $display("FAIL store_idle_stall got %b want 1", stall); end
      tick(); idle_inputs();
      tests++;
      if ({bus_valid, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b1, 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF}) begin
         fails++; $display("FAIL store_req got v=%b we=%b a=%h be=%b wd=%h want 1 1 100 1111 deadbeef",
                           bus_valid, bus_we, bus_addr, bus_be, bus_wdata);
      end
      tick(); bus_ready = 1'b0;
      tests++;
      if ({stall, bus_valid, bus_err} !== 3'b000) begin
         fails++; $display("FAIL store_done got stall/valid/err=%b want 000", {stall, bus_valid, bus_err});
      end
      tests++;
      if (rd_data !== 32'd0) begin fails++; $display("FAIL store_rd_hold got %h want 0", rd_data); end
      tick();
   endtask

   task automatic test_byte_load();
      int n = 0;
      req_rd = 1'b1; data_addr = 32'h203; bus_ready = 1'b0; bus_rdata = 32'h11223344;
      #1; if (stall) n++;
      tick(); idle_inputs();
      tests++;
      if ({bus_addr, bus_be, bus_we} !== {32'h200, 4'b1111, 1'b0}) begin
         fails++; $display("FAIL load_req got a=%h be=%b we=%b want 200 1111 0", bus_addr, bus_be, bus_we);
      end
      for (int w = 0; w < 3; w++) begin
         if (stall) n++;
         tick();
      end
      bus_ready = 1'b1; #1; if (stall) n++;
      tick(); bus_ready = 1'b0;
      tests++;
      if (rd_data !== 32'h00000011) begin fails++; $display("FAIL load_rd_data got %h want 00000011", rd_data); end
      tests++;
      if ({stall, bus_err} !== 2'b00) begin fails++; $display("FAIL load_done got stall/err=%b want 00", {stall, bus_err}); end
      tests++;
      if (n !== 5) begin fails++; $display("FAIL load_stall_cycles got %0d want 5", n); end
      tick();
   endtask

   task automatic test_reset_mid();
      req_rd = 1'b1; data_addr = 32'h44; bus_ready = 1'b0;
      tick(); idle_inputs();
      tick(); rst = 1'b1;
      tick(); rst = 1'b0;
      tests++;
      if ({bus_valid, stall, bus_err, rd_data} !== 35'd0) begin
         fails++; $display("FAIL rstmid got v=%b st=%b err=%b rd=%h want 0 0 0 0", bus_valid, stall, bus_err, rd_data);
      end
      tick();
      tests++;
      if ({bus_valid, bus_err} !== 2'b00) begin fails++; $display("FAIL rstmid_quiet got v/err=%b want 00", {bus_valid, bus_err}); end
      // Following load at offset 1 completes normally.
      req_rd = 1'b1; data_addr = 32'h41; bus_rdata = 32'hCAFEF00D; bus_ready = 1'b1;
      tick(); idle_inputs();
      tests++;
      if ({bus_valid, bus_addr} !== {1'b1, 32'h40}) begin
         fails++; $display("FAIL rstmid_reload_req got v=%b a=%h want 1 40", bus_valid, bus_addr);
      end
      tick(); bus_ready = 1'b0;
      tests++;
      if (rd_data !== 32'h00CAFEF0) begin fails++; $display("FAIL rstmid_reload_data got %h want 00cafef0", rd_data); end
      tick();
   endtask

   task automatic test_timeout();
      int nv = 0;
      int ns = 0;
      bit seen_err = 1'b0;
      req_rd = 1'b1; data_addr = 32'h80; bus_ready = 1'b0;
      #1; if (stall) ns++;
      tick(); idle_inputs();
      for (int c = 0; c < 20 && !seen_err; c++) begin
         if (bus_valid) nv++;
         if (stall) ns++;
         if (bus_err) seen_err = 1'b1;
         else tick();
      end
      tests++;
      if (!seen_err) begin fails++; $display("FAIL timeout_err_seen got 0 want 1"); end
      tests++;
      if (nv !== 4) begin fails++; $display("FAIL timeout_valid_cycles got %0d want 4", nv); end
      tests++;
      if (ns !== 5) begin fails++; $display("FAIL timeout_stall_cycles got %0d want 5", ns); end
      tests++;
      if ({rd_data, bus_valid, stall} !== 34'd0) begin
         fails++; $display("FAIL timeout_err_state got rd=%h v=%b st=%b want 0 0 0", rd_data, bus_valid, stall);
      end
      tick();
      tests++;
      if (bus_err !== 1'b0) begin fails++; $display("FAIL timeout_err_pulse got %b want 0", bus_err); end
   endtask

   task automatic test_store_wins_ready_at_timeout();
      req_rd = 1'b1; dmem_wr = 4'b0011; data_addr = 32'h12; datamem_wr_o = 32'h0000BEEF; bus_ready = 1'b0;
      tick(); idle_inputs();
      tests++;
      if ({bus_we, bus_be, bus_addr} !== {1'b1, 4'b0011, 32'h10}) begin
         fails++; $display("FAIL storewins got we=%b be=%b a=%h want 1 0011 10", bus_we, bus_be, bus_addr);
      end
      tick(); tick(); tick();
      bus_ready = 1'b1;
      tests++;
      if (bus_valid !== 1'b1) begin fails++; $display("FAIL ready_at_to_valid got %b want 1", bus_valid); end
      tick(); bus_ready = 1'b0;
      tests++;
      if ({bus_err, stall, bus_valid} !== 3'b000) begin
         fails++; $display("FAIL ready_at_to_done got err/st/v=%b want 000", {bus_err, stall, bus_valid});
      end
      tick();
      tests++;
      if (bus_err !== 1'b0) begin fails++; $display("FAIL ready_at_to_noerr got %b want 0", bus_err); end
   endtask

   task automatic test_back_to_back();
      int nt = 0;
      int t0 = -1;
      int t1 = -1;
      logic we0 = 1'b0;
      logic we1 = 1'b1;
      bus_ready = 1'b1; bus_rdata = 32'h89ABCDEF;
      for (int c = 0; c < 8; c++) begin
         idle_inputs();
         if (c < 3) begin dmem_wr = 4'b1111; data_addr = 32'h300; datamem_wr_o = 32'h01020304; end
         else if (c < 6) begin req_rd = 1'b1; data_addr = 32'h300; end
         #1;
         if (c == 2 || c == 5) begin
            tests++;
            if (stall !== 1'b0) begin fails++; $display("FAIL b2b_done_stall c=%0d got %b want 0", c, stall); end
         end
         tick();
         if (bus_valid && bus_ready) begin
            if (nt == 0) begin t0 = c + 1; we0 = bus_we; end
            else if (nt == 1) begin t1 = c + 1; we1 = bus_we; end
            nt++;
         end
      end
      idle_inputs(); bus_ready = 1'b0;
      tests++;
      if (nt !== 2) begin fails++; $display("FAIL b2b_count got %0d want 2", nt); end
      tests++;
      if (t1 - t0 !== 3) begin fails++; $display("FAIL b2b_interval got %0d want 3", t1 - t0); end
      tests++;
      if ({we0, we1} !== 2'b10) begin fails++; $display("FAIL b2b_order got we=%b want 10", {we0, we1}); end
      tests++;
      if (rd_data !== 32'h89ABCDEF) begin fails++; $display("FAIL b2b_rd_data got %h want 89abcdef", rd_data); end
   endtask

   initial begin
      test_reset();
      test_word_store();
      test_byte_load();
      test_reset_mid();
      test_timeout();
      test_store_wins_ready_at_timeout();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
